shiftreg8_ctrl: RTL and testbench

SHIFTREG8_CTRL -- requirements
Module: shiftreg8_ctrl

---
 rtl/shiftreg8_ctrl.sv | 118 +++++++++++
 tb/tb_shiftreg8_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg8_ctrl.sv
// Delay line with a selectable depth of 0..3 stages and valid/ready flow control.
// A depth change drains the in-flight samples, then switches depth in one SWITCH cycle.
module shiftreg8_ctrl #(
  parameter logic [1:0] RESET_SEL = 2'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  input  logic        cfg_valid,
  input  logic [1:0]  cfg_sel,
  output logic        cfg_ready,
  output logic [1:0]  cur_sel,
  output logic        busy,
  output logic [15:0] out_count
);

  typedef enum logic [1:0] {RUN, DRAIN, SWITCH} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cur_sel_q, cur_sel_d;
  logic [1:0]      pend_sel_q, pend_sel_d;
  logic [2:0][7:0] s_q, s_d;
  logic [2:0]      v_q, v_d;
  logic [15:0]     cnt_q, cnt_d;

  logic       bypass;
  logic       vk;
  logic [7:0] sk;
  logic       tail_busy;
  logic       adv;

  // Tap selection: stage k is the output stage; tail_busy covers v1..vk only.
  always_comb begin
    vk        = 1'b0;
    sk        = '0;
    tail_busy = 1'b0;
    case (cur_sel_q)
      2'd1: begin vk = v_q[0]; sk = s_q[0]; tail_busy = v_q[0];      end
      2'd2: begin vk = v_q[1]; sk = s_q[1]; tail_busy = |v_q[1:0];   end
      2'd3: begin vk = v_q[2]; sk = s_q[2]; tail_busy = |v_q;        end
      default: ;
    endcase
    bypass = (cur_sel_q == 2'd0);
    adv    = !vk || out_ready;
  end

  always_comb begin
    busy      = (state_q != RUN);
    cfg_ready = (state_q == RUN);
    cur_sel   = cur_sel_q;
    out_count = cnt_q;
    if (bypass) begin
      out_valid = (state_q == RUN) && in_valid;
      out_data  = in_data;
      in_ready  = (state_q == RUN) && out_ready;
    end else begin
      out_valid = (state_q != SWITCH) && vk;
      out_data  = sk;
      in_ready  = (state_q == RUN) && adv;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_sel_d  = cur_sel_q;
    pend_sel_d = pend_sel_q;
    s_d        = s_q;
    v_d        = v_q;
    cnt_d      = cnt_q + 16'(out_valid && out_ready);

    if (!bypass && state_q != SWITCH && adv) begin
      s_d = {s_q[1], s_q[0], in_data};
      v_d = {v_q[1:0], in_valid && in_ready};
    end

    case (state_q)
      RUN: begin
        if (cfg_valid && cfg_sel != cur_sel_q) begin
          pend_sel_d = cfg_sel;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (!tail_busy) state_d = SWITCH;
      end
      SWITCH: begin
        cur_sel_d = pend_sel_q;
        v_d       = '0;
        state_d   = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cur_sel_q  <= RESET_SEL;
      pend_sel_q <= '0;
      s_q        <= '0;
      v_q        <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_sel_q  <= cur_sel_d;
      pend_sel_q <= pend_sel_d;
      s_q        <= s_d;
      v_q        <= v_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_shiftreg8_ctrl.sv
// Scoreboard bench: accepted samples are queued with their acceptance cycle; a monitor
// pops on every output handshake and checks data order, latency and the handshake count.
module tb_shiftreg8_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data, out_data;
  logic        cfg_valid, cfg_ready, busy;
  logic [1:0]  cfg_sel, cur_sel;
  logic [15:0] out_count;

  shiftreg8_ctrl #(.RESET_SEL(2'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_ready(cfg_ready),
    .cur_sel(cur_sel), .busy(busy), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         c;
  } item_t;

  item_t       sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_stall = -1;
  int          model_k = 0;
  logic [15:0] mcnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      mcnt = '0;
    end else begin
      chk("out_count", out_count, mcnt);
      if (in_valid && in_ready) sbq.push_back('{in_data, cyc});
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_output: got %0h expected no output", out_data);
        end else begin
          item_t e;
          e = sbq.pop_front();
          chk("out_data", out_data, e.d);
          if (last_stall < e.c) chk("latency", cyc - e.c, model_k);
        end
        mcnt = mcnt + 16'd1;
      end
      if (!out_ready) last_stall = cyc;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input logic [1:0] sel);
    int n;
    logic last_ov;
    last_ov = 1'b0;
    for (n = 0; n < 40; n++) begin
      if (!busy) break;
      last_ov = out_valid;
      step(); #1;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL busy_timeout: got busy=1 after %0d cycles expected 0", n);
    end
    chk("switch_out_valid", last_ov, 1'b0);
    chk("cur_sel", cur_sel, sel);
  endtask

  task automatic cfg(input logic [1:0] sel);
    int n;
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    out_ready = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cfg_ready) break;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL cfg_timeout: got cfg_ready=0 expected 1");
    end
    step();
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    #1;
    if (sel != model_k[1:0]) begin
      chk("busy_after_cfg", busy, 1'b1);
      wait_idle(sel);
      model_k = int'(sel);
    end else begin
      chk("noop_busy", busy, 1'b0);
      chk("noop_cur_sel", cur_sel, sel);
    end
  endtask

  initial begin
    logic [15:0] base;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_valid = 1'b0; cfg_sel = '0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_cur_sel", cur_sel, 2'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_count", out_count, 16'd0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_bypass_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Bypass with downstream stalled
    in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b0;
    #1;
    chk("byp_out_valid", out_valid, 1'b1);
    chk("byp_out_data", out_data, 8'h5A);
    chk("byp_in_ready", in_ready, 1'b0);
    base = mcnt;
    step();
    in_valid = 1'b0;
    #1 chk("byp_count_hold", out_count, base);

    // Depth 2, three back-to-back samples
    cfg(2'd2);
    out_ready = 1'b1;
    base = mcnt;
    in_valid = 1'b1; in_data = 8'hA1; step();
    in_data = 8'hB2; step();
    in_data = 8'hC3; step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("k2_count", out_count, base + 16'd3);

    // Depth 3, full pipeline with 5-cycle stall
    cfg(2'd3);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h11; step();
    in_data = 8'h22; step();
    in_data = 8'h33; step();
    in_data = 8'h44;
    repeat (5) begin
      #1;
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_out_data", out_data, 8'h11);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();

    // Depth 3 -> 1 with two samples in flight
    in_valid = 1'b1; in_data = 8'hAA; step();
    in_data = 8'hBB; step();
    in_valid = 1'b0;
    cfg(2'd1);
    in_valid = 1'b1; in_data = 8'hCC; step();
    in_valid = 1'b0;
    repeat (3) step();

    // Random traffic with random depth changes
    repeat (8) begin
      cfg(2'($urandom_range(0, 3)));
      repeat (150) begin
        in_valid  = 1'($urandom % 2);
        in_data   = 8'($urandom);
        out_ready = ($urandom % 4) != 0;
        step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) step();
    end

    // Reset in the middle of a drain
    cfg(2'd3);
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h01; step();
    in_data = 8'h02; step();
    in_valid = 1'b0;
    cfg_valid = 1'b1; cfg_sel = 2'd1;
    step();
    cfg_valid = 1'b0;
    #1 chk("drain_busy", busy, 1'b1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_cur_sel", cur_sel, 2'd0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_count", out_count, 16'd0);
    model_k = 0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // Count wrap in bypass
    in_valid = 1'b1;
    repeat (65535) begin
      in_data = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    #1 chk("count_ffff", out_count, 16'hFFFF);
    in_valid = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    #1 chk("count_wrap", out_count, 16'h0000);
    repeat (3) step();

    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
